// File: rtl/vram_port_arbiter.sv
// Two-requester arbiter for the CPU port of a dual-port VRAM.
// Round-robin grant, a single outstanding access, range-checked addresses.
module vram_port_arbiter #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned ADDR_W   = 14,
  parameter int unsigned WORDS    = 1056,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_d,
  output logic              a_ack,
  output logic [WIDTH-1:0]  a_q,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WIDTH-1:0]  b_d,
  output logic              b_ack,
  output logic [WIDTH-1:0]  b_q,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [WIDTH-1:0]  vram_d,
  output logic              vram_we,
  input  logic [WIDTH-1:0]  vram_q,
  output logic              busy,
  output logic              owner
);

  localparam int unsigned CNT_W = 2;
  localparam logic [ADDR_W:0] WORDS_LIM = (ADDR_W+1)'(WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_b_q, last_b_d;
  logic              owner_q, owner_d;
  logic              we_lat_q, we_lat_d;
  logic              in_range_q, in_range_d;
  logic [ADDR_W-1:0] vram_addr_q, vram_addr_d;
  logic [WIDTH-1:0]  vram_d_q, vram_d_d;
  logic              vram_we_q, vram_we_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              a_ack_q, a_ack_d;
  logic [WIDTH-1:0]  a_q_q, a_q_d;
  logic              b_ack_q, b_ack_d;
  logic [WIDTH-1:0]  b_q_q, b_q_d;
  logic              busy_q, busy_d;

  logic              grant_b;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [WIDTH-1:0]  sel_d;
  logic              fin;
  logic [WIDTH-1:0]  fin_data;

  // State and output registers; the pointer resets to B so A wins the first tie
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= IDLE;
      cnt_q       <= CNT_W'(0);
      last_b_q    <= 1'b1;
      owner_q     <= 1'b0;
      we_lat_q    <= 1'b0;
      in_range_q  <= 1'b0;
      vram_addr_q <= ADDR_W'(0);
      vram_d_q    <= WIDTH'(0);
      vram_we_q   <= 1'b0;
      rdata_q     <= WIDTH'(0);
      a_ack_q     <= 1'b0;
      a_q_q       <= WIDTH'(0);
      b_ack_q     <= 1'b0;
      b_q_q       <= WIDTH'(0);
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_b_q    <= last_b_d;
      owner_q     <= owner_d;
      we_lat_q    <= we_lat_d;
      in_range_q  <= in_range_d;
      vram_addr_q <= vram_addr_d;
      vram_d_q    <= vram_d_d;
      vram_we_q   <= vram_we_d;
      rdata_q     <= rdata_d;
      a_ack_q     <= a_ack_d;
      a_q_q       <= a_q_d;
      b_ack_q     <= b_ack_d;
      b_q_q       <= b_q_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_b_d    = last_b_q;
    owner_d     = owner_q;
    we_lat_d    = we_lat_q;
    in_range_d  = in_range_q;
    vram_addr_d = vram_addr_q;
    vram_d_d    = vram_d_q;
    rdata_d     = rdata_q;
    a_q_d       = a_q_q;
    b_q_d       = b_q_q;
    vram_we_d   = 1'b0;
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    fin         = 1'b0;
    fin_data    = rdata_q;

    grant_b  = b_req && (!a_req || !last_b_q);
    sel_we   = grant_b ? b_we   : a_we;
    sel_addr = grant_b ? b_addr : a_addr;
    sel_d    = grant_b ? b_d    : a_d;

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          owner_d     = grant_b;
          we_lat_d    = sel_we;
          vram_addr_d = sel_addr;
          vram_d_d    = sel_d;
          in_range_d  = ({1'b0, sel_addr} < WORDS_LIM);
          vram_we_d   = sel_we && ({1'b0, sel_addr} < WORDS_LIM);
          rdata_d     = WIDTH'(0);
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (we_lat_q) begin
          fin = 1'b1;
        end else begin
          cnt_d   = CNT_W'(READ_LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rdata_d  = in_range_q ? vram_q : WIDTH'(0);
          fin_data = rdata_d;
          fin      = 1'b1;
        end
      end
      DONE: begin
        last_b_d = owner_q;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Completion: ack and data are loaded together so both appear in DONE
    if (fin) begin
      state_d = DONE;
      if (owner_q) begin
        b_ack_d = 1'b1;
        b_q_d   = fin_data;
      end else begin
        a_ack_d = 1'b1;
        a_q_d   = fin_data;
      end
    end

    busy_d = (state_d != IDLE);
  end

  assign a_ack     = a_ack_q;
  assign a_q       = a_q_q;
  assign b_ack     = b_ack_q;
  assign b_q       = b_q_q;
  assign vram_addr = vram_addr_q;
  assign vram_d    = vram_d_q;
  assign vram_we   = vram_we_q;
  assign busy      = busy_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: scoreboarded handshakes on a
// READ_LAT=1 instance plus a directed READ_LAT=3 instance.
module tb_vram_port_arbiter;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned ADDR_W = 14;
  localparam int unsigned WORDS  = 1056;

  typedef struct packed {
    logic              rd;
    logic [WIDTH-1:0]  q;
  } exp_t;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // READ_LAT = 1 instance
  logic              a_req, a_we, b_req, b_we;
  logic [ADDR_W-1:0] a_addr, b_addr;
  logic [WIDTH-1:0]  a_d, b_d;
  logic              a_ack, b_ack, vram_we, busy, owner;
  logic [WIDTH-1:0]  a_q, b_q, vram_d, vram_q;
  logic [ADDR_W-1:0] vram_addr;

  vram_port_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .WORDS(WORDS), .READ_LAT(1)) u_dut (
    .clk(clk), .nreset(nreset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_d(a_d), .a_ack(a_ack), .a_q(a_q),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_d(b_d), .b_ack(b_ack), .b_q(b_q),
    .vram_addr(vram_addr), .vram_d(vram_d), .vram_we(vram_we), .vram_q(vram_q),
    .busy(busy), .owner(owner)
  );

  // READ_LAT = 3 instance
  logic              a3_req, a3_we, b3_req, b3_we;
  logic [ADDR_W-1:0] a3_addr, b3_addr;
  logic [WIDTH-1:0]  a3_d, b3_d;
  logic              a3_ack, b3_ack, vram_we3, busy3, owner3;
  logic [WIDTH-1:0]  a3_q, b3_q, vram_d3, vram_q3;
  logic [ADDR_W-1:0] vram_addr3;

  vram_port_arbiter #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .WORDS(WORDS), .READ_LAT(3)) u_dut3 (
    .clk(clk), .nreset(nreset),
    .a_req(a3_req), .a_we(a3_we), .a_addr(a3_addr), .a_d(a3_d), .a_ack(a3_ack), .a_q(a3_q),
    .b_req(b3_req), .b_we(b3_we), .b_addr(b3_addr), .b_d(b3_d), .b_ack(b3_ack), .b_q(b3_q),
    .vram_addr(vram_addr3), .vram_d(vram_d3), .vram_we(vram_we3), .vram_q(vram_q3),
    .busy(busy3), .owner(owner3)
  );

  // VRAM model, 1-cycle read; out-of-range reads return junk the DUT must mask
  logic [WIDTH-1:0] mem1 [WORDS];
  logic [WIDTH-1:0] pipe1;
  always @(posedge clk) begin
    if (vram_we && (32'(vram_addr) < WORDS)) mem1[int'(vram_addr)] <= vram_d;
    pipe1 <= (32'(vram_addr) < WORDS) ? mem1[int'(vram_addr)] : 32'hBAD0_BAD0;
  end
  assign vram_q = pipe1;

  // 3-cycle ROM model: word = C3C3_0000 | address
  logic [WIDTH-1:0] p3 [3];
  always @(posedge clk) begin
    p3[0] <= 32'hC3C3_0000 | 32'(vram_addr3);
    p3[1] <= p3[0];
    p3[2] <= p3[1];
  end
  assign vram_q3 = p3[2];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard
  logic [WIDTH-1:0] shadow [WORDS];
  exp_t sb_a[$];
  exp_t sb_b[$];
  logic sb_own[$];

  task automatic push_exp(input logic is_b, input logic we, input logic [ADDR_W-1:0] addr,
                          input logic [WIDTH-1:0] d);
    exp_t e;
    e.rd = !we;
    if (32'(addr) < WORDS) e.q = shadow[int'(addr)];
    else e.q = 32'h0;
    if (we && (32'(addr) < WORDS)) shadow[int'(addr)] = d;
    if (is_b) sb_b.push_back(e);
    else sb_a.push_back(e);
    sb_own.push_back(is_b);
  endtask

  // Monitor
  logic [WIDTH-1:0] a_hold = '0, b_hold = '0;
  logic a_hold_v = 1'b1, b_hold_v = 1'b1;
  int we_cnt = 0, busy_cnt = 0, a3_cnt = 0, we3_cnt = 0;
  logic [ADDR_W-1:0] we_addr = '0;

  task automatic mon_ack(input logic is_b);
    exp_t e;
    if (is_b) begin
      chk("ack_excl_b", 32'(a_ack), 32'd0);
      if (a_hold_v) chk("a_q_stable", a_q, a_hold);
      chk("sb_b_nonempty", 32'(sb_b.size() != 0), 32'd1);
      if (sb_b.size() != 0) begin
        e = sb_b.pop_front();
        if (e.rd) begin
          chk("b_rdata", b_q, e.q);
          b_hold = e.q;
        end
        b_hold_v = e.rd;
      end
    end else begin
      chk("ack_excl_a", 32'(b_ack), 32'd0);
      if (b_hold_v) chk("b_q_stable", b_q, b_hold);
      chk("sb_a_nonempty", 32'(sb_a.size() != 0), 32'd1);
      if (sb_a.size() != 0) begin
        e = sb_a.pop_front();
        if (e.rd) begin
          chk("a_rdata", a_q, e.q);
          a_hold = e.q;
        end
        a_hold_v = e.rd;
      end
    end
    chk("order_nonempty", 32'(sb_own.size() != 0), 32'd1);
    if (sb_own.size() != 0) chk("owner", 32'(owner), 32'(sb_own.pop_front()));
  endtask

  always @(negedge clk) begin
    if (!nreset) begin
      a_hold = '0; b_hold = '0; a_hold_v = 1'b1; b_hold_v = 1'b1;
    end else begin
      if (vram_we) begin
        we_cnt++;
        we_addr = vram_addr;
      end
      if (busy) busy_cnt++;
      if (a_ack) mon_ack(1'b0);
      if (b_ack) mon_ack(1'b1);
      if (a3_ack) a3_cnt++;
      if (vram_we3) we3_cnt++;
    end
  end

  task automatic access(input logic is_b, input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [WIDTH-1:0] d, output int lat);
    int t0;
    logic got;
    string tag;
    push_exp(is_b, we, addr, d);
    @(posedge clk); #1;
    if (is_b) begin b_req = 1'b1; b_we = we; b_addr = addr; b_d = d; end
    else begin a_req = 1'b1; a_we = we; a_addr = addr; a_d = d; end
    t0 = cyc;
    got = 1'b0;
    lat = -1;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = is_b ? b_ack : a_ack;
    end
    if (got) lat = cyc - t0;
    tag = is_b ? "b_ack_seen" : "a_ack_seen";
    chk(tag, 32'(got), 32'd1);
    @(posedge clk); #1;
    if (is_b) b_req = 1'b0;
    else a_req = 1'b0;
  endtask

  // Both requesters held; grants must alternate starting with A
  task automatic contend(input logic we, input logic [ADDR_W-1:0] aa, input logic [WIDTH-1:0] ad,
                         input logic [ADDR_W-1:0] ba, input logic [WIDTH-1:0] bd,
                         input int n, output int span);
    int t0, seen;
    for (int i = 0; i < n; i++) begin
      if (i % 2 == 0) push_exp(1'b0, we, aa, ad);
      else push_exp(1'b1, we, ba, bd);
    end
    @(posedge clk); #1;
    a_req = 1'b1; a_we = we; a_addr = aa; a_d = ad;
    b_req = 1'b1; b_we = we; b_addr = ba; b_d = bd;
    t0 = cyc;
    seen = 0;
    span = -1;
    for (int i = 0; i < 100 && seen < n; i++) begin
      @(negedge clk);
      if (a_ack || b_ack) begin
        seen++;
        span = cyc - t0;
      end
    end
    chk("cont_acks", 32'(seen), 32'(n));
    @(posedge clk); #1;
    a_req = 1'b0;
    b_req = 1'b0;
  endtask

  task automatic rl3_read(input logic [ADDR_W-1:0] addr, input logic [WIDTH-1:0] exp_q);
    int t0;
    logic got;
    @(posedge clk); #1;
    b3_req = 1'b1; b3_we = 1'b0; b3_addr = addr;
    t0 = cyc;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = b3_ack;
    end
    chk("rl3_ack_seen", 32'(got), 32'd1);
    chk("rl3_latency", 32'(cyc - t0), 32'd5);
    chk("rl3_b_q", b3_q, exp_q);
    chk("rl3_owner", 32'(owner3), 32'd1);
    @(posedge clk); #1;
    b3_req = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int lat, span, w0, b0;
    a_req = 0; a_we = 0; a_addr = '0; a_d = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_d = '0;
    a3_req = 0; a3_we = 0; a3_addr = '0; a3_d = '0;
    b3_req = 0; b3_we = 0; b3_addr = '0; b3_d = '0;
    nreset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", 32'({a_ack, b_ack, vram_we, busy, owner}), 32'd0);
    chk("rst_a_q", a_q, 32'd0);
    chk("rst_b_q", b_q, 32'd0);
    chk("rst_vram_addr", 32'(vram_addr), 32'd0);
    chk("rst_vram_d", vram_d, 32'd0);
    chk("rst_busy3", 32'(busy3), 32'd0);
    nreset = 1'b1;

    // Single write, then read-back
    w0 = we_cnt;
    access(1'b0, 1'b1, 14'h010, 32'hDEAD_BEEF, lat);
    chk("wr_latency", 32'(lat), 32'd2);
    chk("wr_we_cycles", 32'(we_cnt - w0), 32'd1);
    chk("wr_we_addr", 32'(we_addr), 32'h010);
    b0 = busy_cnt;
    access(1'b0, 1'b0, 14'h010, 32'h0, lat);
    chk("rd_latency", 32'(lat), 32'd3);
    chk("rd_busy_cycles", 32'(busy_cnt - b0), 32'd3);

    // Seed data and contend with reads
    access(1'b1, 1'b1, 14'h020, 32'h0B0B_0B0B, lat);
    access(1'b0, 1'b1, 14'h021, 32'h1111_0021, lat);
    access(1'b1, 1'b0, 14'h020, 32'h0, lat);
    chk("b_rd_latency", 32'(lat), 32'd3);
    contend(1'b0, 14'h010, 32'h0, 14'h020, 32'h0, 4, span);
    chk("cont_rd_span", 32'(span), 32'd15);
    repeat (3) @(negedge clk);
    chk("cont_idle_after", 32'(busy), 32'd0);

    // Range boundaries
    w0 = we_cnt;
    access(1'b1, 1'b1, 14'd1056, 32'h1234_5678, lat);
    chk("oor_wr_latency", 32'(lat), 32'd2);
    access(1'b1, 1'b0, 14'd1056, 32'h0, lat);
    chk("oor_rd_latency", 32'(lat), 32'd3);
    chk("oor_no_we", 32'(we_cnt - w0), 32'd0);
    access(1'b1, 1'b1, 14'd1055, 32'h5A5A_0417, lat);
    chk("top_we_addr", 32'(we_addr), 32'd1055);
    access(1'b1, 1'b0, 14'd1055, 32'h0, lat);
    w0 = we_cnt;
    access(1'b0, 1'b1, 14'h3FFF, 32'hFFFF_FFFF, lat);
    access(1'b0, 1'b0, 14'h3FFF, 32'h0, lat);
    chk("max_addr_no_we", 32'(we_cnt - w0), 32'd0);

    // Reset during WAIT of an A read
    @(posedge clk); #1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 14'h021;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    nreset = 1'b0;
    #1;
    chk("mid_rst_ctrl", 32'({a_ack, b_ack, vram_we, busy, owner}), 32'd0);
    chk("mid_rst_a_q", a_q, 32'd0);
    chk("mid_rst_vram_addr", 32'(vram_addr), 32'd0);
    a_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    nreset = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_idle", 32'(busy), 32'd0);
    contend(1'b1, 14'h030, 32'hA0A0_0030, 14'h031, 32'hB0B0_0031, 2, span);
    chk("cont_wr_span", 32'(span), 32'd5);
    access(1'b0, 1'b0, 14'h021, 32'h0, lat);
    chk("post_rst_rd_latency", 32'(lat), 32'd3);
    access(1'b1, 1'b0, 14'h031, 32'h0, lat);

    // READ_LAT = 3 instance
    rl3_read(14'd5, 32'hC3C3_0005);
    rl3_read(14'd1056, 32'h0);
    chk("rl3_no_a_ack", 32'(a3_cnt), 32'd0);
    chk("rl3_a_q", a3_q, 32'd0);
    chk("rl3_no_we", 32'(we3_cnt), 32'd0);

    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb_a.size() + sb_b.size() + sb_own.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
